// File: rtl/stream_cipher_pkg.sv
// Shared types, constants and the single-bit Galois LFSR step for the stream cipher core.
package stream_cipher_pkg;

   typedef enum logic [1:0] {
      UNKEYED = 2'd0,
      WARM    = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

   // Widest LFSR the step helper handles; narrower states are zero-extended.
   localparam int MAX_LFSR_W = 64;

   // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
   // Zero-extended operands keep the unused upper bits at zero.
   function automatic logic [MAX_LFSR_W-1:0] lfsr_step(input logic [MAX_LFSR_W-1:0] s,
                                                       input logic [MAX_LFSR_W-1:0] taps);
      logic [MAX_LFSR_W-1:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ taps;
      return r;
   endfunction

endpackage

// File: rtl/stream_cipher_core_if.sv
// Bus bundle between the stream cipher core and its user: key control, mode,
// input/output word streams and status.
//
// Handshake: a word moves on a channel in every cycle where valid && ready are
// both high at the rising edge. The producer holds valid and data stable until
// that transfer; ready may depend combinationally on the consumer's state.
interface stream_cipher_core_if
   import stream_cipher_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LFSR_W = 32
);
   logic              key_load;
   logic [LFSR_W-1:0] key;
   logic              fb_mode;
   logic              decrypt;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              keyed;
   logic [15:0]       word_cnt;
   state_t            state;      // current FSM state, for observation

   modport master (
      output key_load, key, fb_mode, decrypt, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, keyed, word_cnt, state
   );

   modport slave (
      input  key_load, key, fb_mode, decrypt, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, keyed, word_cnt, state
   );
endinterface

// File: rtl/lfsr_keystream.sv
// Keystream state: holds the LFSR, advances it DATA_W bits per word in one
// cycle, applies ciphertext feedback and substitutes 1 for an all-zero key.
module lfsr_keystream
   import stream_cipher_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [LFSR_W-1:0] key,
   input  logic              step_en,   // advance one word this cycle
   input  logic              fb_en,     // fold fb_word into the stepped state
   input  logic [DATA_W-1:0] fb_word,
   output logic [DATA_W-1:0] ks         // keystream for the current word
);

   logic [LFSR_W-1:0] s_q;
   logic [LFSR_W-1:0] s_step;
   logic [LFSR_W-1:0] s_next;
   logic [LFSR_W-1:0] seed;

   // Unrolled word step followed by the optional feedback fold.
   always_comb begin
      s_step = s_q;
      for (int i = 0; i < DATA_W; i++) begin
         s_step = LFSR_W'(lfsr_step(MAX_LFSR_W'(s_step), MAX_LFSR_W'(TAPS)));
      end
      s_next = s_step;
      if (fb_en) s_next[DATA_W-1:0] = s_step[DATA_W-1:0] ^ fb_word;
      // An all-zero state would lock the LFSR, so a zero key seeds with 1.
      seed = (key == '0) ? LFSR_W'(1) : key;
   end

   // State register: key load has priority over stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           s_q <= '0;
      else if (key_load) s_q <= seed;
      else if (step_en)  s_q <= s_next;
   end

   assign ks = s_q[DATA_W-1:0];

endmodule

// File: rtl/stream_cipher_core.sv
// Keyed stream-cipher datapath: key/warmup FSM, input accept logic, registered
// output word and accepted-word counter around the LFSR keystream.
module stream_cipher_core
   import stream_cipher_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
   parameter int                WARMUP = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   stream_cipher_core_if.slave  bus
);

   localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

   state_t            state_q, state_d;
   logic [15:0]       warm_q, warm_d;
   logic              in_ready;
   logic              keyed;
   logic              accept;
   logic              step_en;
   logic              fb_en;
   logic [DATA_W-1:0] ks;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] cipher;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [15:0]       cnt_q;

   // FSM state register and warmup counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNKEYED;
         warm_q  <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
      end
   end

   // Next state: key_load restarts warmup from any state.
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      if (bus.key_load) begin
         warm_d  = '0;
         state_d = (WARMUP == 0) ? RUN : WARM;
      end else begin
         case (state_q)
            WARM: begin
               if (warm_q == WARM_LAST) state_d = RUN;
               else                     warm_d  = warm_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // FSM outputs: readiness, accept qualification and keystream stepping.
   always_comb begin
      keyed    = (state_q == RUN);
      in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
      accept   = bus.in_valid && in_ready && !bus.key_load;
      step_en  = accept || ((state_q == WARM) && !bus.key_load);
      fb_en    = accept && bus.fb_mode;
   end

   // Result word and the ciphertext value fed back in feedback mode.
   always_comb begin
      result = bus.in_data ^ ks;
      cipher = bus.decrypt ? bus.in_data : result;
   end

   lfsr_keystream #(
      .DATA_W (DATA_W),
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS)
   ) u_keystream (
      .clk      (clk),
      .rst      (rst),
      .key_load (bus.key_load),
      .key      (bus.key),
      .step_en  (step_en),
      .fb_en    (fb_en),
      .fb_word  (cipher),
      .ks       (ks)
   );

   // Output register: key_load drops any pending word; data holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (bus.key_load) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Accepted-word counter since the last key load; wraps freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt_q <= '0;
      else if (bus.key_load) cnt_q <= '0;
      else if (accept)       cnt_q <= cnt_q + 16'd1;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.keyed     = keyed;
   assign bus.word_cnt  = cnt_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_stream_cipher_core.sv
// Bench for stream_cipher_core: one instance with WARMUP = 0 and one with
// WARMUP = 4, both DATA_W = 8, LFSR_W = 32, default taps.
module tb_stream_cipher_core;
   import stream_cipher_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference keystream state for the WARMUP = 4 instance.
   logic [31:0] m_s;
   int          m_cnt;

   always #5 clk = ~clk;

   stream_cipher_core_if #(.DATA_W(8), .LFSR_W(32)) if0 ();
   stream_cipher_core_if #(.DATA_W(8), .LFSR_W(32)) if4 ();

   stream_cipher_core #(.DATA_W(8), .LFSR_W(32), .WARMUP(0)) dut0 (
      .clk (clk), .rst (rst), .bus (if0)
   );
   stream_cipher_core #(.DATA_W(8), .LFSR_W(32), .WARMUP(4)) dut4 (
      .clk (clk), .rst (rst), .bus (if4)
   );

   // ---------------- model ----------------
   function automatic logic [31:0] m_bit(input logic [31:0] s);
      logic b;
      b = s[0];
      s = s >> 1;
      if (b) s = s ^ 32'h8020_0003;
      return s;
   endfunction

   task automatic m_load(input logic [31:0] k, input int warm);
      m_s = (k == 32'd0) ? 32'd1 : k;
      repeat (warm * 8) m_s = m_bit(m_s);
      m_cnt = 0;
   endtask

   task automatic m_word(input logic [7:0] din, input logic fb, input logic dec,
                         output logic [7:0] dout);
      dout = din ^ m_s[7:0];
      for (int i = 0; i < 8; i++) m_s = m_bit(m_s);
      if (fb) m_s[7:0] = m_s[7:0] ^ (dec ? din : dout);
      m_cnt++;
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key0(input logic [31:0] k);
      if0.key      = k;
      if0.key_load = 1'b1;
      tick();
      if0.key_load = 1'b0;
   endtask

   task automatic key4(input logic [31:0] k);
      if4.key      = k;
      if4.key_load = 1'b1;
      tick();
      if4.key_load = 1'b0;
      repeat (4) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) tick();
      n_checks++;
      if ({if4.out_valid, if4.in_ready, if4.keyed} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {if4.out_valid, if4.in_ready, if4.keyed});
      else n_pass++;
      n_checks++;
      if (if4.out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", if4.out_data);
      else n_pass++;
      n_checks++;
      if (if4.word_cnt !== 16'd0) $display("FAIL reset_word_cnt: got %0d expected 0", if4.word_cnt);
      else n_pass++;
      n_checks++;
      if (if4.state !== UNKEYED) $display("FAIL reset_state: got %0d expected %0d", if4.state, UNKEYED);
      else n_pass++;
      rst = 1'b0;
      if0.in_valid = 1'b1;
      if4.in_valid = 1'b1;
      if0.in_data  = 8'h5A;
      if4.in_data  = 8'h5A;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if ({if0.in_ready, if0.out_valid, if0.keyed, if4.in_ready, if4.out_valid, if4.keyed} !== 6'b0)
            $display("FAIL unkeyed_blocked: got %b expected 000000 at cycle %0d",
                     {if0.in_ready, if0.out_valid, if0.keyed, if4.in_ready, if4.out_valid, if4.keyed}, i);
         else n_pass++;
      end
      if0.in_valid = 1'b0;
      if4.in_valid = 1'b0;
   endtask

   // key = 1 from hand: word ks 01 then 02 (state 0x0000_0001 -> 0xDB36_C002).
   task automatic test_plain_warmup0();
      key0(32'h1);
      n_checks++;
      if (if0.keyed !== 1'b1) $display("FAIL w0_keyed: got %b expected 1", if0.keyed);
      else n_pass++;
      if0.in_valid = 1'b1;
      if0.in_data  = 8'h00;
      tick();
      n_checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h01) $display("FAIL w0_word0: got v=%b %h expected v=1 01", if0.out_valid, if0.out_data);
      else n_pass++;
      tick();
      if0.in_valid = 1'b0;
      n_checks++;
      if (if0.out_data !== 8'h02) $display("FAIL w0_word1: got %h expected 02", if0.out_data);
      else n_pass++;
      n_checks++;
      if (if0.word_cnt !== 16'd2) $display("FAIL w0_word_cnt: got %0d expected 2", if0.word_cnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_zero_key();
      key0(32'h0);
      if0.in_valid = 1'b1;
      if0.in_data  = 8'hA5;
      tick();
      n_checks++;
      if (if0.out_data !== 8'hA4) $display("FAIL zero_key_word0: got %h expected a4", if0.out_data);
      else n_pass++;
      if0.in_data = 8'h3C;
      tick();
      if0.in_valid = 1'b0;
      n_checks++;
      if (if0.out_data !== 8'h3E) $display("FAIL zero_key_word1: got %h expected 3e", if0.out_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_warmup();
      if4.in_valid  = 1'b0;
      if4.out_ready = 1'b1;
      if4.key       = 32'hCAFE_F00D;
      if4.key_load  = 1'b1;
      tick();
      if4.key_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (if4.in_ready !== 1'b0 || if4.keyed !== 1'b0 || if4.state !== WARM)
            $display("FAIL warm_phase: got rdy=%b keyed=%b st=%0d expected 0 0 %0d at %0d", if4.in_ready, if4.keyed, if4.state, WARM, i);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (if4.keyed !== 1'b1 || if4.in_ready !== 1'b1) $display("FAIL warm_done: got keyed=%b rdy=%b expected 1 1", if4.keyed, if4.in_ready);
      else n_pass++;
   endtask

   task automatic test_fb_roundtrip();
      logic [7:0] pt [3];
      logic [7:0] cap[3];
      logic [7:0] e;
      pt[0] = 8'h01; pt[1] = 8'h02; pt[2] = 8'h03;
      if4.out_ready = 1'b1;
      if4.fb_mode   = 1'b1;
      if4.decrypt   = 1'b0;
      key4(32'hDEAD_BEEF);
      m_load(32'hDEAD_BEEF, 4);
      if4.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if4.in_data = pt[i];
         m_word(pt[i], 1'b1, 1'b0, e);
         tick();
         cap[i] = if4.out_data;
         n_checks++;
         if (if4.out_data !== e) $display("FAIL fb_encrypt%0d: got %h expected %h", i, if4.out_data, e);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
      tick();
      if4.decrypt = 1'b1;
      key4(32'hDEAD_BEEF);
      if4.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if4.in_data = cap[i];
         tick();
         n_checks++;
         if (if4.out_data !== pt[i]) $display("FAIL fb_decrypt%0d: got %h expected %h", i, if4.out_data, pt[i]);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
      tick();
      // Plain mode ignores direction: decrypt of the same words equals encrypt.
      pt[0] = 8'h11; pt[1] = 8'h22; pt[2] = 8'h33;
      if4.fb_mode = 1'b0;
      if4.decrypt = 1'b0;
      key4(32'hDEAD_BEEF);
      m_load(32'hDEAD_BEEF, 4);
      if4.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if4.in_data = pt[i];
         m_word(pt[i], 1'b0, 1'b0, e);
         tick();
         cap[i] = if4.out_data;
         n_checks++;
         if (if4.out_data !== e) $display("FAIL plain_encrypt%0d: got %h expected %h", i, if4.out_data, e);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
      tick();
      if4.decrypt = 1'b1;
      key4(32'hDEAD_BEEF);
      if4.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if4.in_data = pt[i];
         tick();
         n_checks++;
         if (if4.out_data !== cap[i]) $display("FAIL plain_dec_eq_enc%0d: got %h expected %h", i, if4.out_data, cap[i]);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
      if4.decrypt  = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] w[4];
      logic [7:0] e[4];
      w[0] = 8'h10; w[1] = 8'h9F; w[2] = 8'hE7; w[3] = 8'h42;
      if4.fb_mode   = 1'b0;
      if4.out_ready = 1'b1;
      key4(32'h1234_5678);
      m_load(32'h1234_5678, 4);
      if4.out_ready = 1'b0;
      if4.in_valid  = 1'b1;
      if4.in_data   = w[0];
      m_word(w[0], 1'b0, 1'b0, e[0]);
      tick();
      if4.in_data = w[1];
      #1;
      n_checks++;
      if (if4.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", if4.in_ready);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (if4.out_valid !== 1'b1 || if4.out_data !== e[0]) $display("FAIL stall_hold%0d: got v=%b %h expected v=1 %h", i, if4.out_valid, if4.out_data, e[0]);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (if4.word_cnt !== 16'd1) $display("FAIL stall_word_cnt: got %0d expected 1", if4.word_cnt);
      else n_pass++;
      if4.out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         if4.in_data = w[i];
         m_word(w[i], 1'b0, 1'b0, e[i]);
         tick();
         n_checks++;
         if (if4.out_valid !== 1'b1 || if4.out_data !== e[i]) $display("FAIL stream%0d: got v=%b %h expected v=1 %h", i, if4.out_valid, if4.out_data, e[i]);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
      tick();
      n_checks++;
      if (if4.out_valid !== 1'b0) $display("FAIL drain: got v=%b expected 0", if4.out_valid);
      else n_pass++;
      n_checks++;
      if (if4.word_cnt !== 16'(m_cnt)) $display("FAIL stream_word_cnt: got %0d expected %0d", if4.word_cnt, m_cnt);
      else n_pass++;
   endtask

   task automatic test_key_load_priority();
      logic [7:0] e;
      if4.fb_mode   = 1'b0;
      if4.out_ready = 1'b0;
      if4.in_valid  = 1'b1;
      if4.in_data   = 8'h55;
      tick();
      // Pending word plus a would-be accept in the same cycle as key_load.
      if4.out_ready = 1'b1;
      if4.in_data   = 8'h66;
      if4.key       = 32'h0BAD_F00D;
      if4.key_load  = 1'b1;
      tick();
      if4.key_load = 1'b0;
      n_checks++;
      if (if4.out_valid !== 1'b0) $display("FAIL kl_drop: got v=%b expected 0", if4.out_valid);
      else n_pass++;
      n_checks++;
      if (if4.word_cnt !== 16'd0) $display("FAIL kl_word_cnt: got %0d expected 0", if4.word_cnt);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (if4.in_ready !== 1'b0 || if4.word_cnt !== 16'd0) $display("FAIL kl_warm%0d: got rdy=%b cnt=%0d expected 0 0", i, if4.in_ready, if4.word_cnt);
         else n_pass++;
         tick();
      end
      m_load(32'h0BAD_F00D, 4);
      m_word(8'h66, 1'b0, 1'b0, e);
      n_checks++;
      if (if4.in_ready !== 1'b1) $display("FAIL kl_ready: got %b expected 1", if4.in_ready);
      else n_pass++;
      tick();
      if4.in_valid = 1'b0;
      n_checks++;
      if (if4.out_valid !== 1'b1 || if4.out_data !== e) $display("FAIL kl_restart: got v=%b %h expected v=1 %h", if4.out_valid, if4.out_data, e);
      else n_pass++;
      n_checks++;
      if (if4.word_cnt !== 16'd1) $display("FAIL kl_restart_cnt: got %0d expected 1", if4.word_cnt);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      if4.out_ready = 1'b0;
      if4.in_valid  = 1'b1;
      if4.in_data   = 8'h77;
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({if4.out_valid, if4.in_ready, if4.keyed} !== 3'b000 || if4.out_data !== 8'h00 || if4.word_cnt !== 16'd0)
         $display("FAIL async_reset: got v=%b rdy=%b keyed=%b d=%h cnt=%0d expected 0 0 0 00 0",
                  if4.out_valid, if4.in_ready, if4.keyed, if4.out_data, if4.word_cnt);
      else n_pass++;
      tick();
      rst = 1'b0;
      if4.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (if4.in_ready !== 1'b0 || if4.keyed !== 1'b0) $display("FAIL key_lost%0d: got rdy=%b keyed=%b expected 0 0", i, if4.in_ready, if4.keyed);
         else n_pass++;
      end
      if4.in_valid = 1'b0;
   endtask

   initial begin
      if0.key_load = 1'b0; if0.key = '0; if0.fb_mode = 1'b0; if0.decrypt = 1'b0;
      if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
      if4.key_load = 1'b0; if4.key = '0; if4.fb_mode = 1'b0; if4.decrypt = 1'b0;
      if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
      m_s   = '0;
      m_cnt = 0;

      test_reset();
      test_plain_warmup0();
      test_zero_key();
      test_warmup();
      test_fb_roundtrip();
      test_back_to_back();
      test_key_load_priority();
      test_async_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stream_cipher_core.md
# stream_cipher_core

Parametrised keyed stream-cipher datapath. Generates an LFSR keystream of DATA_W bits per word and XORs it with an incoming word stream under a valid/ready handshake. Supports an optional ciphertext-feedback mode in which encrypt and decrypt differ, so the mode input has a real effect. Sits between the pad-level I/O wrapper and the user design and replaces the fixed 8-bit cipher path.

## Interface
Parameters:
- DATA_W, 8: word width; 1..LFSR_W.
- LFSR_W, 32: keystream state width.
- TAPS, 32'h8020_0003: Galois feedback mask, LFSR_W bits.
- WARMUP, 4: words of keystream discarded after each key load; 0 allowed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  load key this cycle.
- key  in  LFSR_W  seed.
- fb_mode  in  1  0 = plain XOR stream; 1 = ciphertext feedback. Sampled per word.
- decrypt  in  1  direction, sampled per word; only matters when fb_mode = 1.
- in_valid  in  1  input word offered.
- in_ready  out  1  core accepts the word this cycle.
- in_data  in  DATA_W  plaintext or ciphertext.
- out_valid  out  1  result word held.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  result word.
- keyed  out  1  key loaded and warmup complete.
- word_cnt  out  16  words accepted since the last key load; wraps at 16'hFFFF→0.

## Operation
State machine (state_t):
- UNKEYED: entered on reset. Input is blocked.
- WARM: entered on key_load. Steps the LFSR once per cycle, WARMUP times, with in_ready = 0.
- RUN: entered from WARM when the warmup count is exhausted. Enters RUN directly from key_load when WARMUP = 0.

Key load:
- State ← key.
- key == 0 loads 1, to avoid LFSR lockup.

Step function:
- Applied DATA_W times per word, unrolled in one cycle.
- Per bit: b = s[0]; s = s >> 1; if b, s ^= TAPS.

Keystream and result:
- ks = s[DATA_W-1:0], taken before the step.
- out_data = in_data ^ ks.

Feedback (fb_mode = 1):
- After the step, the low DATA_W bits of s are XORed with the ciphertext word.
- The ciphertext word is out_data when encrypting and in_data when decrypting.
- This makes encrypt/decrypt pairs with the same key, mode and word sequence mutually inverse.

Handshake:
- in_ready = (state == RUN) && (!out_valid || out_ready).
- An accept is in_valid && in_ready. It advances the LFSR and increments word_cnt.

key_load priority:
- key_load wins over any simultaneous accept. The accept is ignored and the LFSR is not advanced for it.
- out_valid is cleared, dropping any pending word.
- word_cnt resets to 0.
- key_load in any state, including mid-WARM, restarts warmup.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 0, keyed 0, word_cnt 0, state UNKEYED, LFSR 0.
- Latency: a word accepted in cycle N appears with out_valid = 1 in cycle N+1.
- Throughput: 1 word per cycle while out_ready = 1.
- out_data is held stable while out_valid && !out_ready.
- keyed rises in the cycle the state becomes RUN, which is WARMUP+1 cycles after the key_load cycle.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous). The key is lost and a new key_load is required.
- word_cnt wrap has no side effects.

## Structure
- stream_cipher_pkg: state_t enum (UNKEYED, WARM, RUN), default TAPS constant, and a function lfsr_step(s, taps) giving a single-bit Galois step.
- Sub-module lfsr_keystream holds the state register, the unrolled DATA_W-step logic, the feedback XOR and the zero-key substitution.
- The top level holds the FSM, warmup counter, output register and word counter.

## Test plan
All scenarios use DATA_W = 8, LFSR_W = 32 and default TAPS unless stated.
- Reset with no key; drive in_valid = 1 for 10 cycles → in_ready, out_valid and keyed stay 0.
- WARMUP = 0, key = 32'h1, fb_mode = 0; send 8'h00 → out_data = 8'h01 one cycle after accept.
- WARMUP = 4, key = 32'hDEADBEEF, fb_mode = 1, encrypt 8'h01, 8'h02, 8'h03. Reload the same key, decrypt the captured outputs → 8'h01, 8'h02, 8'h03 returned. For comparison, plain mode with decrypt = 1 must equal encrypt.
- key = 0 → behaviour identical to key = 32'h1.
- Hold out_ready = 0 with a word pending → in_ready = 0 and out_data stable. Release → exactly one transfer per cycle with no loss or duplication. word_cnt matches the model.
- key_load asserted in the same cycle as an accept with a pending output → output dropped, word_cnt = 0, in_ready low for WARMUP+1 cycles, and the keystream restarts from the new key.
